// File: rtl/arm_mem_pkg.sv
// Shared definitions for the instruction-memory responder and its storage array.
package arm_mem_pkg;

  localparam int unsigned INSTR_W    = 32;
  // Byte address to word index shift.
  localparam int unsigned WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port (preload), one asynchronous read port.
// The responder registers the read data on the same edge a write may land, so a
// collision on one word returns the old contents (read-before-write).
module imem_array
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [INSTR_W-1:0]             wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [INSTR_W-1:0]             rdata
);

  logic [INSTR_W-1:0] mem [DEPTH_WORDS];

  // Preload write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_responder.sv
// Memory end of the IF-stage fetch interface: accepts a PC, answers after LATENCY
// cycles, raises busy while the fetch is outstanding, and drops the fetch on cancel.
module inst_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [31:0]                    req_addr,
  input  logic                           cancel,
  output logic                           resp_valid,
  output logic [INSTR_W-1:0]             resp_instr,
  output logic                           resp_err,
  output logic                           busy,
  input  logic                           ld_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [INSTR_W-1:0]             ld_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // WAIT lasts LATENCY-1 cycles; the counter reaches zero on the last one.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               mis_q, mis_d;
  logic [INSTR_W-1:0] resp_instr_q, resp_instr_d;
  logic               resp_err_q, resp_err_d;

  logic [AW-1:0]      req_idx;
  logic               req_mis;
  logic [AW-1:0]      rd_idx;
  logic               rd_mis;
  logic [INSTR_W-1:0] rd_data;
  logic               load_resp;

  // Upper PC bits beyond the array wrap are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+WORD_SHIFT];

  assign req_idx = req_addr[WORD_SHIFT +: AW];
  assign req_mis = (req_addr[1:0] != 2'b00);

  // With LATENCY=1 the array is read in the accept cycle, so address the live request.
  assign rd_idx = (state_q == StIdle) ? req_idx : idx_q;
  assign rd_mis = (state_q == StIdle) ? req_mis : mis_q;

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (ld_we),
    .waddr(ld_addr),
    .wdata(ld_data),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  // State, counter, captured request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      mis_q        <= 1'b0;
      resp_instr_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      mis_q        <= mis_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, present in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    mis_d        = mis_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    load_resp    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !cancel) begin
          idx_d = req_idx;
          mis_d = req_mis;
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d   = StResp;
            load_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d   = StResp;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load_resp) begin
      resp_instr_d = rd_mis ? '0 : rd_data;
      resp_err_d   = rd_mis;
    end
  end

  // Outputs: cancel masks both the pulse and busy combinationally.
  always_comb begin
    resp_valid = (state_q == StResp) && !cancel;
    busy       = !cancel && (((state_q == StIdle) && req_valid) || (state_q == StWait));
    resp_instr = resp_instr_q;
    resp_err   = resp_err_q;
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_inst_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        cancel;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        resp_err;
  logic        busy;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  int total = 0;
  int bad   = 0;

  inst_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .cancel    (cancel),
    .resp_valid(resp_valid),
    .resp_instr(resp_instr),
    .resp_err  (resp_err),
    .busy      (busy),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding fetch at most; it is answered LAT cycles after acceptance
  // unless cancel or reset intervenes.
  logic [31:0] mm [DEPTH];
  bit          seen_rst = 0;
  bit          pend     = 0;
  int          t_acc    = 0;
  int          cyc      = 0;
  int          p_idx    = 0;
  bit          p_mis    = 0;
  logic [31:0] last_instr = '0;
  logic        last_err   = 1'b0;

  always @(negedge clk) begin
    logic exp_busy, exp_rv, accept_now;
    int   a_idx;
    if (!pend) begin
      exp_busy = req_valid && !cancel;
      exp_rv   = 1'b0;
    end else if (cyc == t_acc + LAT) begin
      exp_busy = 1'b0;
      exp_rv   = !cancel;
    end else begin
      exp_busy = !cancel;
      exp_rv   = 1'b0;
    end
    if (seen_rst) begin
      chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("model_resp_valid", {31'd0, resp_valid}, {31'd0, exp_rv});
      chk("model_resp_instr", resp_instr, last_instr);
      chk("model_resp_err", {31'd0, resp_err}, {31'd0, last_err});
    end
    accept_now = !pend && req_valid && !cancel && !rst;
    a_idx = int'((req_addr / 4) % DEPTH);
    // Response data is taken from memory before this edge's preload write.
    if (accept_now && LAT == 1) begin
      last_instr = (req_addr % 4 != 0) ? 32'd0 : mm[a_idx];
      last_err   = (req_addr % 4 != 0);
    end else if (pend && cyc == t_acc + LAT - 1 && !cancel && !rst) begin
      last_instr = p_mis ? 32'd0 : mm[p_idx];
      last_err   = p_mis;
    end
    if (ld_we) mm[ld_addr] = ld_data;
    if (rst) begin
      pend       = 0;
      last_instr = '0;
      last_err   = 1'b0;
      seen_rst   = 1;
    end else if (pend) begin
      if (cancel || cyc == t_acc + LAT) pend = 0;
    end else if (accept_now) begin
      pend  = 1;
      t_acc = cyc;
      p_idx = a_idx;
      p_mis = (req_addr % 4 != 0);
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = 8'(a);
    ld_data = d;
    next_cycle();
    ld_we = 1'b0;
  endtask

  // Holds the PC through the fetch and checks the literal timing and result.
  task automatic fetch_lit(input logic [31:0] addr, input logic [31:0] ei, input logic ee);
    req_valid = 1'b1;
    req_addr  = addr;
    for (int k = 0; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k < int'(LAT)) begin
        chk("lit_busy_pending", {31'd0, busy}, 32'd1);
        chk("lit_no_resp_pending", {31'd0, resp_valid}, 32'd0);
      end else begin
        chk("lit_busy_resp", {31'd0, busy}, 32'd0);
        chk("lit_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lit_resp_instr", resp_instr, ei);
        chk("lit_resp_err", {31'd0, resp_err}, {31'd0, ee});
      end
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] exp_seq [3];
    int n, last_k;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; cancel = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_instr", resp_instr, 32'd0);
    next_cycle();

    for (int i = 0; i < 32; i++) load(i, 32'hC0DE_0000 | 32'(i));
    load(1, 32'hE3A01005);

    // Basic fetch of word 1.
    fetch_lit(32'h4, 32'hE3A01005, 1'b0);
    next_cycle();

    // Back-to-back fetches, IF stage advances only when busy drops.
    exp_seq[0] = 32'hC0DE_0000;
    exp_seq[1] = 32'hE3A01005;
    exp_seq[2] = 32'hC0DE_0002;
    pc = 32'h0; n = 0; last_k = 0;
    req_valid = 1'b1;
    req_addr  = pc;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        chk("b2b_data", resp_instr, exp_seq[n]);
        if (n > 0) chk("b2b_spacing", 32'(k - last_k), 32'(LAT + 1));
        last_k = k;
        n++;
      end
      if (!busy && resp_valid) pc = pc + 32'd4;
      next_cycle();
      req_addr = pc;
      if (n == 3) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("b2b_count", 32'(n), 32'd3);
    next_cycle();

    // Cancel an in-flight fetch, branch target accepted two cycles after accept.
    req_valid = 1'b1;
    req_addr  = 32'h8;
    @(negedge clk);
    chk("cancel_accept_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_busy_masked", {31'd0, busy}, 32'd0);
    chk("cancel_no_resp", {31'd0, resp_valid}, 32'd0);
    next_cycle();
    cancel = 1'b0;
    fetch_lit(32'h40, 32'hC0DE_0010, 1'b0);
    next_cycle();

    // Misaligned request and wrap-around address.
    fetch_lit(32'h6, 32'h0, 1'b1);
    fetch_lit(32'(DEPTH * 4 + 4), 32'hE3A01005, 1'b0);
    next_cycle();

    // Preload of word 2 on the same edge as the response read returns old data.
    req_valid = 1'b1;
    req_addr  = 32'h8;
    next_cycle();
    next_cycle();
    ld_we = 1'b1; ld_addr = 8'd2; ld_data = 32'h5A5A_5A5A;
    next_cycle();
    ld_we = 1'b0;
    @(negedge clk);
    chk("collide_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("collide_old_data", resp_instr, 32'hC0DE_0002);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    fetch_lit(32'h8, 32'h5A5A_5A5A, 1'b0);
    next_cycle();

    // Reset while waiting drops the fetch silently.
    req_valid = 1'b1;
    req_addr  = 32'h4;
    next_cycle();
    req_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_wait_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("rst_wait_instr", resp_instr, 32'd0);
      chk("rst_wait_busy", {31'd0, busy}, 32'd0);
      next_cycle();
    end

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Multi-cycle instruction-memory responder: the memory end of the fetch interface driven by the IF stage. It accepts a fetch request (PC), returns the 32-bit instruction word after a fixed LATENCY, and drives busy into the pipeline freeze logic while the fetch is outstanding. A branch cancel aborts an in-flight fetch. A side-band load port preloads program memory.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two.
- LATENCY, 3: cycles from accept cycle to response cycle; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  IF stage presents a fetch this cycle.
- req_addr  in  32  byte address (PC).
- cancel  in  1  Branch_taken/flush; aborts the outstanding fetch.
- resp_valid  out  1  instruction valid this cycle, one-cycle pulse.
- resp_instr  out  32  fetched instruction; 0 on error.
- resp_err  out  1  misaligned request; qualified by resp_valid.
- busy  out  1  fetch outstanding, not yet answered; feeds freeze.
- ld_we  in  1  preload write enable.
- ld_addr  in  log2(DEPTH_WORDS)  preload word index.
- ld_data  in  32  preload data.

## Operation
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- FSM states:
  - IDLE: req_valid & ~cancel accepts the request. Captures word index = req_addr[2 +: log2(DEPTH_WORDS)], so the address wraps modulo depth. Captures misalign = (req_addr[1:0] != 0). Next state is WAIT, or RESP directly when LATENCY=1.
  - WAIT: down-counter runs. On the last WAIT cycle, the array is read into resp_instr/resp_err registers; next state is RESP.
  - RESP: resp_valid = ~cancel. Next state is always IDLE. No request is accepted in RESP, because the IF stage still presents the old PC in that cycle.
- Cancel handling:
  - cancel in any state: next state is IDLE and no response is produced for that fetch.
  - cancel combinationally masks resp_valid and busy in the same cycle.
- busy = ~cancel & ((IDLE & req_valid) | WAIT). It is combinational from req_valid, so the IF stage freezes in the accept cycle itself.
- Misaligned request: full latency is still spent. Response gives resp_err=1 and resp_instr=0.
- Preload: write occurs at the clock edge when ld_we=1, in any state.
  - Same-edge collision with the response read of the same word returns the old data (read-before-write).
  - ld_addr is a word index, so no alignment check applies.
- req_addr and req_valid are ignored outside IDLE; the captured address is used.
- Reset:
  - state=IDLE, counter=0, resp_instr=0, resp_err=0; therefore resp_valid=0 and busy=0 (when req_valid=0).
  - Memory contents are not reset.
  - rst mid-fetch drops the fetch silently.

## Timing
- Accept cycle T is an IDLE cycle with req_valid=1 and cancel=0.
- busy=1 in cycles T..T+LATENCY-1 and 0 in cycle T+LATENCY.
- resp_valid=1 in cycle T+LATENCY only, with resp_instr/resp_err stable in that cycle.
- Next accept is at the earliest in T+LATENCY+1, giving a throughput of one fetch per LATENCY+1 cycles.
- LATENCY=1: T accept, T+1 response.
- cancel in cycle C (T ≤ C ≤ T+LATENCY): busy=0 and resp_valid=0 in C; IDLE in C+1, where a new req (branch target) is accepted.
- resp_instr holds its value after the pulse until the next response load or reset.

## Structure
- Shared package arm_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - INSTR_W=32;
  - WORD_SHIFT=2.
- Sub-module imem_array: DEPTH_WORDS x 32 storage with one synchronous write port (preload) and one read port. Read-before-write applies on collision.
- The FSM, counter, capture registers and output logic sit in inst_mem_responder.

## Test plan
- Preload word 1=0xE3A01005, then req_addr=0x4 held with LATENCY=3, accept at T: busy=1 in T..T+2; resp_valid=1 and resp_instr=0xE3A01005 only in T+3; busy=0 in T+3.
- Back-to-back PCs 0x0, 0x4, 0x8 with the IF-stage model advancing only when busy=0: three responses, each 4 cycles apart, with correct data.
- Accept 0x8, assert cancel at T+1, present 0x40 at T+2: no response for 0x8; 0x40 is accepted at T+2 and answered at T+5.
- req_addr=0x6: resp_valid at T+LATENCY with resp_err=1 and resp_instr=0. Also req_addr=DEPTH_WORDS*4+0x4 returns word 1 (wrap).
- ld_we writes word 2 on the same edge as the response read of word 2: old data is returned, and a refetch returns the new data.
- rst asserted in WAIT: next cycle IDLE, resp_valid never pulses; resp_instr=0, busy=0 with req_valid=0.
